// File: rtl/hand_fifo.sv
// hand_fifo: elastic buffer between a valid/ready source and sink.
// Handshake outputs decode only the registered occupancy, never the inputs.
module hand_fifo #(
    parameter int L     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [L-1:0]            s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [L-1:0]            m_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [L-1:0]  mem_q [DEPTH];
    logic [L-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    assign full        = cnt_q == CW'(DEPTH);
    assign empty       = cnt_q == '0;
    assign almost_full = cnt_q >= CW'(DEPTH - 1);
    assign s_ready     = !full;
    assign m_valid     = !empty;
    assign m_data      = mem_q[rp_q];
    assign count       = cnt_q;
    // A full buffer refuses s_valid even when a pop frees a slot this cycle.
    assign push        = s_valid && !full;
    assign pop         = m_ready && !empty;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = s_data;
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hand_fifo.sv
// tb_hand_fifo: directed stimulus feeds an expected-word queue; a negedge
// monitor pops it on every accepted output word and compares m_data.
module tb_hand_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [2:0] count;
    logic       full, empty, almost_full;

    logic [7:0] q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    hand_fifo #(.L(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves at the next edge whenever m_valid && m_ready here.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(m_data), 32'h1ff);
                end else begin
                    check("out_word", 32'(m_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fill_d [4] = '{8'h56, 8'ha8, 8'h37, 8'hbe};
        logic [7:0] sim_d  [6] = '{8'hf7, 8'hce, 8'h22, 8'hbe, 8'h33, 8'ha8};
        logic       pat    [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int         mc;
        logic [7:0] d;
        logic       acc, pp;

        repeat (2) step();
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_m_data", 32'(m_data), 0);
        rst = 1'b0;
        step();

        // Reset asserted mid-cycle with three words buffered.
        s_valid = 1'b1;
        s_data = 8'h11; step();
        s_data = 8'h22; step();
        s_data = 8'h33; step();
        s_valid = 1'b0;
        check("pre_rst_count", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        check("async_m_valid", 32'(m_valid), 0);
        check("async_count", 32'(count), 0);
        check("async_s_ready", 32'(s_ready), 1);
        check("async_m_data", 32'(m_data), 0);
        q.delete();
        step();
        rst = 1'b0;
        step();

        // Fill with the sink stalled, then hold 8'h33 against a full buffer.
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = fill_d[i];
            q.push_back(fill_d[i]);
            step();
            check("fill_count", 32'(count), i + 1);
            check("fill_head", 32'(m_data), 8'h56);
            check("fill_af", 32'(almost_full), (i >= 2) ? 1 : 0);
        end
        check("full_flag", 32'(full), 1);
        check("full_s_ready", 32'(s_ready), 0);
        s_data = 8'h33;
        q.push_back(8'h33);
        repeat (2) step();
        check("stall_count", 32'(count), 4);
        check("stall_head", 32'(m_data), 8'h56);

        // Drain: 8'h33 is taken on the edge after the first pop.
        m_ready = 1'b1;
        step();
        check("reopen_s_ready", 32'(s_ready), 1);
        check("reopen_count", 32'(count), 3);
        step();
        s_valid = 1'b0;
        check("drain_count", 32'(count), 3);
        repeat (3) step();
        m_ready = 1'b0;
        check("drain_empty", 32'(empty), 1);
        check("drain_m_valid", 32'(m_valid), 0);

        // Simultaneous push and pop at count 2.
        s_valid = 1'b1;
        s_data = 8'h11; q.push_back(8'h11); step();
        s_data = 8'h22; q.push_back(8'h22); step();
        check("pre_sim_count", 32'(count), 2);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = sim_d[i];
            q.push_back(sim_d[i]);
            step();
            check("sim_count", 32'(count), 2);
        end
        s_valid = 1'b0;
        repeat (2) step();
        check("sim_empty", 32'(empty), 1);

        // Streaming through pointer wrap: each word is at the head one cycle later.
        s_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            s_data = 8'(i);
            q.push_back(8'(i));
            step();
            check("wrap_head", 32'(m_data), i);
            check("wrap_count", 32'(count), 1);
        end
        s_valid = 1'b0;
        step();
        m_ready = 1'b0;
        check("wrap_empty", 32'(empty), 1);

        // Toggling ready with random data; a count model decides acceptance.
        mc = 0;
        d = 8'($urandom_range(255));
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 6; i++) begin
            m_ready = pat[i];
            acc = mc < 4;
            pp = pat[i] && mc > 0;
            if (acc) q.push_back(d);
            mc = mc + (acc ? 1 : 0) - (pp ? 1 : 0);
            step();
            check("tog_count", 32'(count), mc);
            if (q.size() > 0) check("tog_head", 32'(m_data), 32'(q[0]));
            if (acc) begin
                d = 8'($urandom_range(255));
                s_data = d;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (mc) step();
        m_ready = 1'b0;
        check("tog_empty", 32'(empty), 1);

        step();
        check("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
